// File: rtl/cmp_unit_pipe.sv
// ---------------------------------------------------------------------------
// cmp_unit_pipe
//   Two-stage pipelined integer comparator. Stage 1 compares the low LO_W
//   bits (borrow + equality). Stage 2 finishes the compare on the high bits
//   and selects the funct3 result into the output registers. A valid/ready
//   handshake runs on both ends, and a synchronous flush drops both stages.
//
//   Optional feature macro: CMP_MINMAX_EN
//     defined   : i_op is 4 bits; i_op[3]=1 selects MIN/MAX/MINU/MAXU
//                 (returns the chosen full operand).
//     undefined : i_op is 3 bits; compare/branch ops only.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_flush   synchronous flush of both stages
//   i_valid   operands/op valid
//   o_ready   operands accepted this cycle when i_valid is high
//   i_a, i_b  operands (WIDTH bits)
//   i_op      funct3 in [2:0] (plus min/max select in [3] when enabled)
//   o_valid   result valid
//   i_ready   downstream accepts result
//   o_result  {zeros, flag} or selected min/max operand
//   o_taken   branch/flag bit (selector bit for min/max)
// ---------------------------------------------------------------------------
module cmp_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int LO_W  = WIDTH / 2,
`ifdef CMP_MINMAX_EN
  localparam int OPW  = 4
`else
  localparam int OPW  = 3
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OPW-1:0]   i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_taken
);

  localparam int HI_W = WIDTH - LO_W;

  // Handshake
  logic s1_adv_s;
  logic s2_adv_s;

  // Stage 1 combinational
  logic [LO_W-1:0] a_lo_s;
  logic [LO_W-1:0] b_lo_s;
  logic            bl_s;
  logic            eql_s;

  // Stage 1 registers
  logic            s1_valid_r;
  logic            s1_bl_r;
  logic            s1_eql_r;
  logic [HI_W-1:0] s1_a_hi_r;
  logic [HI_W-1:0] s1_b_hi_r;
  logic [OPW-1:0]  s1_op_r;
`ifdef CMP_MINMAX_EN
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
`endif

  // Stage 2 combinational
  logic             eqh_s;
  logic             eq_s;
  logic             ltu_s;
  logic             lt_s;
  logic             sign_a_s;
  logic             sign_b_s;
  logic             flag_s;
  logic [WIDTH-1:0] res_s;
  logic             taken_s;

  assign s2_adv_s = ~o_valid | i_ready;
  assign s1_adv_s = ~s1_valid_r | s2_adv_s;
  assign o_ready  = s1_adv_s & ~i_flush;

  // Low-half compare: the borrow of A_lo - B_lo is simply A_lo < B_lo.
  assign a_lo_s = i_a[LO_W-1:0];
  assign b_lo_s = i_b[LO_W-1:0];
  assign bl_s   = (a_lo_s < b_lo_s) ? 1'b1 : 1'b0;
  assign eql_s  = (a_lo_s == b_lo_s) ? 1'b1 : 1'b0;

  // Stage 1 register: captures low-half partial results and the high halves on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_r <= 1'b0;
      s1_bl_r    <= 1'b0;
      s1_eql_r   <= 1'b0;
      s1_a_hi_r  <= {HI_W{1'b0}};
      s1_b_hi_r  <= {HI_W{1'b0}};
      s1_op_r    <= {OPW{1'b0}};
`ifdef CMP_MINMAX_EN
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
`endif
    end else if (i_flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      // Outside a flush o_ready equals s1_adv_s, so i_valid alone means accept.
      s1_valid_r <= i_valid;
      if (i_valid) begin
        s1_bl_r   <= bl_s;
        s1_eql_r  <= eql_s;
        s1_a_hi_r <= i_a[WIDTH-1:LO_W];
        s1_b_hi_r <= i_b[WIDTH-1:LO_W];
        s1_op_r   <= i_op;
`ifdef CMP_MINMAX_EN
        s1_a_r    <= i_a;
        s1_b_r    <= i_b;
`endif
      end
    end
  end

  // High-half completion. The borrow out of {A_hi} - {B_hi} - bl is
  // (A_hi < B_hi) | (A_hi == B_hi & bl). When the signs agree the signed
  // order equals the unsigned order, so the top difference bit equals ltu.
  assign eqh_s    = (s1_a_hi_r == s1_b_hi_r) ? 1'b1 : 1'b0;
  assign eq_s     = s1_eql_r & eqh_s;
  assign ltu_s    = ((s1_a_hi_r < s1_b_hi_r) ? 1'b1 : 1'b0) | (eqh_s & s1_bl_r);
  assign sign_a_s = s1_a_hi_r[HI_W-1];
  assign sign_b_s = s1_b_hi_r[HI_W-1];
  assign lt_s     = (sign_a_s != sign_b_s) ? sign_a_s : ltu_s;

  // funct3 compare select.
  always_comb begin
    flag_s = 1'b0;
    case (s1_op_r[2:0])
      3'b000:  flag_s = eq_s;
      3'b001:  flag_s = ~eq_s;
      3'b010:  flag_s = lt_s;
      3'b011:  flag_s = ltu_s;
      3'b100:  flag_s = lt_s;
      3'b101:  flag_s = ~lt_s;
      3'b110:  flag_s = ltu_s;
      3'b111:  flag_s = ~ltu_s;
      default: flag_s = 1'b0;
    endcase
  end

  // Result/taken select (compare flag, or min/max operand when enabled).
  always_comb begin
    res_s   = {WIDTH{1'b0}};
    taken_s = 1'b0;
`ifdef CMP_MINMAX_EN
    if (s1_op_r[3]) begin
      case (s1_op_r[2:0])
        3'b100:  taken_s = lt_s;    // MIN : A when A < B
        3'b101:  taken_s = ~lt_s;   // MAX : A when A >= B
        3'b110:  taken_s = ltu_s;   // MINU
        3'b111:  taken_s = ~ltu_s;  // MAXU
        default: taken_s = 1'b0;    // reserved
      endcase
      if (s1_op_r[2]) begin
        res_s = taken_s ? s1_a_r : s1_b_r;
      end else begin
        res_s = {WIDTH{1'b0}};
      end
    end else begin
      res_s   = {{(WIDTH-1){1'b0}}, flag_s};
      taken_s = flag_s;
    end
`else
    res_s   = {{(WIDTH-1){1'b0}}, flag_s};
    taken_s = flag_s;
`endif
  end

  // Stage 2 / output register: advances when empty or drained; holds under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_result <= {WIDTH{1'b0}};
      o_taken  <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (s2_adv_s) begin
      o_valid <= s1_valid_r;
      if (s1_valid_r) begin
        o_result <= res_s;
        o_taken  <= taken_s;
      end
    end
  end

endmodule
